// File: rtl/jt7759_romsrv_if.sv
// Request/response bus used on both sides of the JT7759 ROM server.
// The control side carries byte requests (17-bit address, 8-bit data).
// The memory side carries word requests (16-bit address, 16-bit data).
// The master drives cs/addr. The slave answers with data/ok.
interface jt7759_romsrv_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cs;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ok;

    modport master (output cs, addr, input  data, ok);
    modport slave  (input  cs, addr, output data, ok);
endinterface

// File: rtl/jt7759_romsrv.sv
// ROM responder for the JT7759 control FSM.
// Serves byte reads from a two-word buffer: the current word plus a
// prefetched next word. The buffer is filled from a variable-latency
// 16-bit memory port with a cs/ok handshake.
module jt7759_romsrv #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jt7759_romsrv_if.slave        rom,   // 17-bit byte address, 8-bit data
    jt7759_romsrv_if.master       mem    // 16-bit word address, 16-bit data
);

    typedef enum logic [1:0] {IDLE, PROMO, FETCH, PREF} state_t;

    state_t      state, state_nx;

    logic [15:0] cur_tag,  cur_tag_nx;
    logic [15:0] cur_word, cur_word_nx;
    logic        cur_vld,  cur_vld_nx;
    logic [15:0] pre_tag,  pre_tag_nx;
    logic [15:0] pre_word, pre_word_nx;
    logic        pre_vld,  pre_vld_nx;
    logic        mem_cs,   mem_cs_nx;
    logic [15:0] mem_addr, mem_addr_nx;
    logic [7:0]  rom_data;
    logic        rom_ok;

    logic [15:0] req_tag;
    logic        cur_hit;
    logic        pre_hit;
    logic [15:0] next_tag;
    logic        ack;

    assign req_tag  = rom.addr[16:1];
    assign cur_hit  = cur_vld && (cur_tag == req_tag);
    assign pre_hit  = pre_vld && (pre_tag == req_tag);
    assign next_tag = mem_addr + 16'd1;   // 16-bit wrap: FFFF -> 0000
    assign ack      = mem_cs && mem.ok;   // an ok with no request is ignored

    assign rom.data = rom_data;
    assign rom.ok   = rom_ok;
    assign mem.cs   = mem_cs;
    assign mem.addr = mem_addr;

    // Next-state and next-buffer logic for the fetch/prefetch FSM.
    always_comb begin
        // NOTE: every target gets a hold value first, so no path through the case can infer a latch.
        state_nx    = state;
        cur_tag_nx  = cur_tag;
        cur_word_nx = cur_word;
        cur_vld_nx  = cur_vld;
        pre_tag_nx  = pre_tag;
        pre_word_nx = pre_word;
        pre_vld_nx  = pre_vld;
        mem_cs_nx   = mem_cs;
        mem_addr_nx = mem_addr;

        case (state)
            IDLE: begin
                if (rom.cs && !cur_hit) begin
                    if (pre_hit) begin
                        // Promote on the way into PROMO so that the hit is
                        // visible to the output register one edge later.
                        // This gives a 2-cycle latency.
                        cur_tag_nx  = pre_tag;
                        cur_word_nx = pre_word;
                        cur_vld_nx  = 1'b1;
                        pre_vld_nx  = 1'b0;
                        state_nx    = PROMO;
                    end else begin
                        mem_addr_nx = req_tag;
                        mem_cs_nx   = 1'b1;
                        state_nx    = FETCH;
                    end
                end
            end
            PROMO: begin
                if (PREFETCH) begin
                    mem_addr_nx = cur_tag + 16'd1;
                    mem_cs_nx   = 1'b1;
                    state_nx    = PREF;
                end else begin
                    state_nx    = IDLE;
                end
            end
            FETCH: begin
                // The fill always lands, even if rom_cs dropped or the address moved.
                if (ack) begin
                    cur_tag_nx  = mem_addr;
                    cur_word_nx = mem.data;
                    cur_vld_nx  = 1'b1;
                    mem_cs_nx   = 1'b0;
                    // Skip the prefetch when pre already holds the next word.
                    // This keeps requests for resident tags off the bus.
                    if (PREFETCH && !(pre_vld && pre_tag == next_tag)) begin
                        mem_addr_nx = next_tag;
                        state_nx    = PREF;
                    end else begin
                        state_nx    = IDLE;
                    end
                end
            end
            PREF: begin
                // Entered with mem_cs low after a demand fill.
                // The request is raised here and held until acknowledged.
                if (ack) begin
                    pre_tag_nx  = mem_addr;
                    pre_word_nx = mem.data;
                    pre_vld_nx  = 1'b1;
                    mem_cs_nx   = 1'b0;
                    state_nx    = IDLE;
                end else begin
                    mem_cs_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, buffer and memory-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            cur_tag  <= '0;
            cur_word <= '0;
            cur_vld  <= 1'b0;
            pre_tag  <= '0;
            pre_word <= '0;
            pre_vld  <= 1'b0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nx;
            cur_tag  <= cur_tag_nx;
            cur_word <= cur_word_nx;
            cur_vld  <= cur_vld_nx;
            pre_tag  <= pre_tag_nx;
            pre_word <= pre_word_nx;
            pre_vld  <= pre_vld_nx;
            mem_cs   <= mem_cs_nx;
            mem_addr <= mem_addr_nx;
        end
    end

    // Registered byte response: ok on a current-word hit; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ok   <= 1'b0;
            rom_data <= '0;
        end else begin
            rom_ok <= rom.cs && cur_hit;
            if (rom.cs && cur_hit)
                rom_data <= rom.addr[0] ? cur_word[15:8] : cur_word[7:0];
        end
    end

endmodule

// File: tb/tb_jt7759_romsrv.sv
// Directed bench for jt7759_romsrv.
// Two instances are used: PREFETCH=1 (u0) and PREFETCH=0 (u1).
// Expected bytes go to a scoreboard queue when a read is issued.
// They are popped and compared when rom_ok arrives.
// The memory models log every request address for later comparison.
module tb_jt7759_romsrv;

    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    jt7759_romsrv_if #(.AW(17), .DW(8))  ri0 ();
    jt7759_romsrv_if #(.AW(17), .DW(8))  ri1 ();
    jt7759_romsrv_if #(.AW(16), .DW(16)) mi0 ();
    jt7759_romsrv_if #(.AW(16), .DW(16)) mi1 ();

    jt7759_romsrv #(.PREFETCH(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .rom(ri0), .mem(mi0));
    jt7759_romsrv #(.PREFETCH(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .rom(ri1), .mem(mi1));

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb [$];
    logic [15:0] log0 [$];
    logic [15:0] log1 [$];

    logic        ok0 = 1'b0, ok1 = 1'b0, inj_ok = 1'b0;
    logic [15:0] d0 = '0, d1 = '0;
    int          cnt0 = 0, cnt1 = 0;

    assign mi0.ok   = ok0 | inj_ok;
    assign mi0.data = d0;
    assign mi1.ok   = ok1;
    assign mi1.data = d1;

    function automatic logic [15:0] word_of(input logic [15:0] t);
        return {8'hA4 ^ t[7:0], 8'h5B ^ t[15:8] ^ t[7:0]};
    endfunction

    function automatic logic [7:0] byte_of(input logic [16:0] a);
        logic [15:0] w;
        w = word_of(a[16:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model for u0: acks LAT cycles after a request and logs its address.
    always @(negedge clk) begin
        if (!rst_n) begin
            ok0 = 1'b0; cnt0 = 0;
        end else if (ok0) begin
            ok0 = 1'b0; cnt0 = 0;
        end else if (mi0.cs) begin
            cnt0++;
            if (cnt0 == 1) log0.push_back(mi0.addr);
            if (cnt0 >= LAT) begin
                ok0 = 1'b1;
                d0  = word_of(mi0.addr);
            end
        end
    end

    // Memory model for u1.
    always @(negedge clk) begin
        if (!rst_n) begin
            ok1 = 1'b0; cnt1 = 0;
        end else if (ok1) begin
            ok1 = 1'b0; cnt1 = 0;
        end else if (mi1.cs) begin
            cnt1++;
            if (cnt1 == 1) log1.push_back(mi1.addr);
            if (cnt1 >= LAT) begin
                ok1 = 1'b1;
                d1  = word_of(mi1.addr);
            end
        end
    end

    // Present a byte address, then wait (bounded) for rom_ok and score the byte.
    task automatic rd(input int which, input logic [16:0] a, input int exp_lat, input string tag);
        int         cyc;
        logic       got;
        logic [7:0] dat;
        logic [7:0] exp;
        sb.push_back(byte_of(a));
        if (which == 0) begin ri0.cs = 1'b1; ri0.addr = a; end
        else            begin ri1.cs = 1'b1; ri1.addr = a; end
        cyc = 0;
        got = 1'b0;
        dat = '0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            got = (which == 0) ? ri0.ok   : ri1.ok;
            dat = (which == 0) ? ri0.data : ri1.data;
        end
        exp = sb.pop_front();
        check({tag, " rom_ok"}, got, 1'b1);
        if (got) check({tag, " rom_data"}, dat, exp);
        if (exp_lat > 0) check({tag, " latency"}, cyc, exp_lat);
    endtask

    // Pop the oldest logged memory request and compare its address.
    task automatic pop_req(input int which, input logic [15:0] exp, input string tag);
        logic        present;
        logic [15:0] v;
        present = (which == 0) ? (log0.size() > 0) : (log1.size() > 0);
        check({tag, " present"}, present, 1'b1);
        if (present) begin
            v = (which == 0) ? log0.pop_front() : log1.pop_front();
            check({tag, " mem_addr"}, v, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ri0.cs   = 1'b0; ri0.addr = '0;
        ri1.cs   = 1'b0; ri1.addr = '0;
        inj_ok   = 1'b0;
        repeat (3) @(negedge clk);

        check("reset rom_ok",   ri0.ok,   1'b0);
        check("reset rom_data", ri0.data, 8'h00);
        check("reset mem_cs",   mi0.cs,   1'b0);
        check("reset mem_addr", mi0.addr, 16'h0000);

        rst_n = 1'b1;
        @(negedge clk);

        // Cold read: FETCH (3-cycle memory) then one cycle to rom_ok.
        rd(0, 17'h00003, 5, "cold");
        check("cold byte", ri0.data, 8'hA5);
        repeat (10) @(negedge clk);
        pop_req(0, 16'h0001, "cold demand");
        pop_req(0, 16'h0002, "cold prefetch");

        // Sequential stream: promotions at 2 cycles, hits at 1 cycle, prefetch only.
        rd(0, 17'h00004, 2, "seq4");
        rd(0, 17'h00005, 1, "seq5");
        repeat (10) @(negedge clk);
        rd(0, 17'h00006, 2, "seq6");
        rd(0, 17'h00007, 1, "seq7");
        repeat (10) @(negedge clk);
        pop_req(0, 16'h0003, "seq prefetch a");
        pop_req(0, 16'h0004, "seq prefetch b");
        check("seq no demand", log0.size(), 0);

        // Pulse tolerance: one low cycle between bytes of the same word.
        rd(0, 17'h00010, 5, "pulse first");
        repeat (10) @(negedge clk);
        pop_req(0, 16'h0008, "pulse demand");
        pop_req(0, 16'h0009, "pulse prefetch");
        ri0.cs = 1'b0;
        @(negedge clk);
        check("pulse gap rom_ok", ri0.ok, 1'b0);
        rd(0, 17'h00011, 1, "pulse second");
        repeat (4) @(negedge clk);
        check("pulse no extra mem_cs", log0.size(), 0);

        // Miss while a prefetch is outstanding, with tag wrap on the next prefetch.
        rd(0, 17'h00020, 5, "jump base");
        check("jump pref outstanding", mi0.cs, 1'b1);
        rd(0, 17'h1FFFE, 0, "jump far");
        ri0.cs = 1'b0;
        repeat (10) @(negedge clk);
        pop_req(0, 16'h0010, "jump demand");
        pop_req(0, 16'h0011, "jump prefetch");
        pop_req(0, 16'hFFFF, "jump far demand");
        pop_req(0, 16'h0000, "jump wrap prefetch");

        // Demand-only instance: two requests for four sequential bytes.
        rd(1, 17'h00020, 5, "nopf 20");
        rd(1, 17'h00021, 1, "nopf 21");
        rd(1, 17'h00022, 5, "nopf 22");
        rd(1, 17'h00023, 1, "nopf 23");
        ri1.cs = 1'b0;
        repeat (4) @(negedge clk);
        pop_req(1, 16'h0010, "nopf req a");
        pop_req(1, 16'h0011, "nopf req b");
        check("nopf request count", log1.size(), 0);

        // Reset in the middle of a FETCH, then a stray ack after release.
        ri0.cs   = 1'b1;
        ri0.addr = 17'h00100;
        @(negedge clk);
        check("rst fetch mem_cs", mi0.cs, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst async mem_cs", mi0.cs, 1'b0);
        check("rst async rom_ok", ri0.ok, 1'b0);
        @(negedge clk);
        ri0.cs = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        log0.delete();
        @(negedge clk);
        inj_ok = 1'b1;
        @(negedge clk);
        inj_ok   = 1'b0;
        ri0.cs   = 1'b1;
        ri0.addr = 17'h00000;
        @(negedge clk);
        check("late ack rom_ok",   ri0.ok,   1'b0);
        check("late ack mem_cs",   mi0.cs,   1'b1);
        check("late ack mem_addr", mi0.addr, 16'h0000);
        ri0.cs = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
